ps2_key_decoder: RTL
====================

// Module: ps2_key_decoder
// PURPOSE
//  Receives raw PS/2 keyboard frames and decodes set-2 scan codes into the key[5:0] held-key mask and keycode[7:0] used by the game FSM.
//  Sits between the PS/2 pins (via the top level) and the menu/game control logic, all in the pclk domain.
//  Tracks the E0 (extended) and F0 (break) prefixes so arrow keys and key releases are decoded correctly.
// PARAMETERS
//  TIMEOUT_CYCLES  130000  max pclk cycles between PS/2 falling edges inside a frame (2 ms @ 65 MHz) before the frame is aborted
// PORTS
//  pclk       in   1  system clock, single clock domain
//  rst        in   1  asynchronous, active-high reset
//  ps2_clk    in   1  raw PS/2 clock line, asynchronous to pclk
//  ps2_data   in   1  raw PS/2 data line, asynchronous to pclk
//  key        out  6  held-key mask: [0] up, [1] down, [2] left, [3] right, [4] enter, [5] space
//  keycode    out  8  last make code still held (0 = none); the E0 prefix is not included
//  key_event  out  1  one-cycle pulse on every decoded make code, typematic repeats included
//  frame_err  out  1  one-cycle pulse when a frame is dropped
// BEHAVIOUR
//  - Reset: key=0, keycode=0, key_event=0, frame_err=0, both FSMs idle, synchronisers=1, timeout counter=0.
//  - Input path: ps2_clk and ps2_data each pass through a 2-FF synchroniser. A falling edge is registered synced-clk 1->0, and ps2_data is sampled on that edge.
//  - Frame receiver states: IDLE -> DATA(8 bits, LSB first) -> PARITY -> STOP -> IDLE.
//    - IDLE: a sampled 0 (start bit) enters DATA. A sampled 1 is ignored.
//    - STOP: stop bit=1 produces a 1-cycle internal byte_valid. Stop bit=0 drops the frame and pulses frame_err.
//    - Timeout: in DATA, PARITY or STOP, a counter reaching TIMEOUT_CYCLES-1 with no falling edge drops the frame, pulses frame_err and returns to IDLE. The counter clears on every falling edge.
//  - Decoder states: BASE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). Bytes are consumed only on byte_valid.
//    - BASE: E0 -> EXT; F0 -> BRK; any other byte is a make of a non-extended code -> BASE.
//    - EXT: F0 -> EXT_BRK; any other byte is an extended make -> BASE.
//    - BRK and EXT_BRK: the byte is a break of that code -> BASE.
//    - Bytes E1, AA, FA, FE, EE, 00, FF are discarded in all states. Each one returns the FSM to BASE.
//  - Key mapping:
//    - Extended: 75 up, 72 down, 6B left, 74 right.
//    - Non-extended: 5A enter, 29 space.
//    - Extended 5A (keypad enter) also maps to enter.
//  - Make: set the mapped key bit, set keycode=byte, pulse key_event. Unmapped makes still update keycode and pulse key_event.
//  - Break: clear the mapped key bit. Set keycode=0 only if the byte equals the current keycode.
//  - Latency: key, keycode and key_event update 1 pclk after byte_valid. byte_valid is 1 pclk after the stop-bit edge is detected.
//  - Several keys held: several key bits are set at once. The consumer's equality compares then fail, which is intended (no action on chords).
//  - Repeated make of a held key: the bit stays set and key_event pulses again.
//  - An E0 or F0 prefix followed by a frame error: the decoder keeps the prefix state. The next good byte completes the sequence.
//  - rst mid-frame: immediate return to reset state. The partial frame is discarded with no frame_err.
// CONFIGURATION
//  PS2_PARITY_CHECK_EN defined:
//    - odd parity is checked over the 8 data bits plus the parity bit;
//    - on a mismatch, the frame is dropped, frame_err pulses and no byte_valid is raised.
//  PS2_PARITY_CHECK_EN undefined:
//    - the parity bit is sampled and ignored;
//    - frame_err comes only from a bad stop bit or a timeout.
// STRUCTURE
//  Shared package ps2_pkg:
//    - scan-code constants (CODE_E0, CODE_F0, CODE_UP=8'h75, CODE_DOWN=8'h72, CODE_LEFT=8'h6B, CODE_RIGHT=8'h74, CODE_ENTER=8'h5A, CODE_SPACE=8'h29);
//    - KEY_* one-hot values (KEY_UP=6'b000001 ... KEY_SPACE=6'b100000), shared with main_fsm;
//    - decoder state encodings.
//  Sub-module ps2_frame_rx: synchronisers, edge detect, frame FSM, timeout and parity check. Outputs byte[7:0], byte_valid, frame_err.
//  The decoder FSM and key mapping live in ps2_key_decoder.
// TESTING
//  1. Frame E0,75 then E0,F0,75 at a 12.5 kHz PS/2 clock -> key=6'b000001 after the second frame, keycode=8'h75, one key_event; key=0 and keycode=0 after the break.
//  2. Frame 5A with a correct stop bit -> key=6'b010000, keycode=8'h5A; then F0,5A -> key=0, keycode=0.
//  3. Hold left (E0 6B), press right (E0 74), release left -> key goes 6'b000100, then 6'b001100, then 6'b001000; keycode=8'h74 throughout the left release.
//  4. Make 1C ('A') -> key unchanged (0), keycode=8'h1C, key_event pulses; break F0 1C -> keycode=0.
//  5. Stop the PS/2 clock after 4 data bits -> frame_err pulses TIMEOUT_CYCLES after the last edge; a following full frame 29 decodes correctly (key[5]=1).
//  6. With PS2_PARITY_CHECK_EN: byte 5A sent with even parity -> frame_err pulses, key stays 0. Without the macro: key=6'b010000.

Source files
------------

// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 set-2 scan-code constants, held-key one-hot values,
//               frame/decoder state encodings and scan-code helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

  // Prefix and control bytes
  localparam logic [7:0] CODE_E0    = 8'hE0;
  localparam logic [7:0] CODE_F0    = 8'hF0;
  localparam logic [7:0] CODE_E1    = 8'hE1;
  localparam logic [7:0] CODE_AA    = 8'hAA;
  localparam logic [7:0] CODE_FA    = 8'hFA;
  localparam logic [7:0] CODE_FE    = 8'hFE;
  localparam logic [7:0] CODE_EE    = 8'hEE;
  localparam logic [7:0] CODE_00    = 8'h00;
  localparam logic [7:0] CODE_FF    = 8'hFF;

  // Mapped key codes
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_ENTER = 8'h5A;
  localparam logic [7:0] CODE_SPACE = 8'h29;

  // Held-key one-hot bits, shared with the game FSM
  localparam logic [5:0] KEY_UP     = 6'b000001;
  localparam logic [5:0] KEY_DOWN   = 6'b000010;
  localparam logic [5:0] KEY_LEFT   = 6'b000100;
  localparam logic [5:0] KEY_RIGHT  = 6'b001000;
  localparam logic [5:0] KEY_ENTER  = 6'b010000;
  localparam logic [5:0] KEY_SPACE  = 6'b100000;

  // Frame receiver states
  typedef enum logic [1:0] {
    FR_IDLE   = 2'd0,
    FR_DATA   = 2'd1,
    FR_PARITY = 2'd2,
    FR_STOP   = 2'd3
  } frame_state_t;

  // Scan-code decoder states
  typedef enum logic [1:0] {
    DEC_BASE    = 2'd0,
    DEC_EXT     = 2'd1,
    DEC_BRK     = 2'd2,
    DEC_EXT_BRK = 2'd3
  } dec_state_t;

  // Bytes that carry no key information and reset any pending prefix
  function automatic logic is_discard(input logic [7:0] code);
    logic r;
    r = 1'b0;
    case (code)
      CODE_E1, CODE_AA, CODE_FA, CODE_FE, CODE_EE, CODE_00, CODE_FF: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Held-key bit for a scan code; extended and plain codes map differently
  function automatic logic [5:0] key_mask(input logic [7:0] code, input logic ext);
    logic [5:0] m;
    m = 6'b000000;
    if (ext) begin
      case (code)
        CODE_UP:    m = KEY_UP;
        CODE_DOWN:  m = KEY_DOWN;
        CODE_LEFT:  m = KEY_LEFT;
        CODE_RIGHT: m = KEY_RIGHT;
        CODE_ENTER: m = KEY_ENTER;  // keypad enter
        default:    m = 6'b000000;
      endcase
    end else begin
      case (code)
        CODE_ENTER: m = KEY_ENTER;
        CODE_SPACE: m = KEY_SPACE;
        default:    m = 6'b000000;
      endcase
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_frame_rx.sv
// ============================================================================
// Module      : ps2_frame_rx
// Description : PS/2 frame receiver. Synchronises the raw PS/2 lines, detects
//               falling clock edges, shifts in start/8 data/parity/stop bits
//               and reports each good byte or a dropped frame.
//               Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 130000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int c_TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT_CYCLES - 1);

  logic            r_clk_s1, r_clk_s2, r_clk_d;
  logic            r_dat_s1, r_dat_s2;
  logic            w_fall;
  logic            w_par_ok;

  frame_state_t    r_state, w_state_nxt;
  logic [2:0]      r_bit_cnt, w_cnt_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic [c_TW-1:0] r_timer, w_timer_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_err, w_err_nxt;

`ifdef PS2_PARITY_CHECK_EN
  logic            r_par, w_par_nxt;
  assign w_par_ok = ^{r_shift, r_par};
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_fall = r_clk_d & ~r_clk_s2;

  // Two-flop synchronisers plus a delayed copy of the clock for edge detection
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Frame state, shift register, timeout counter and result pulses
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state   <= FR_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_timer   <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_timer   <= w_timer_nxt;
      r_valid   <= w_valid_nxt;
      r_err     <= w_err_nxt;
`ifdef PS2_PARITY_CHECK_EN
      r_par     <= w_par_nxt;
`endif
    end
  end

  // Next-state logic: one bit per falling edge, abort on a stalled clock
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_timer_nxt = '0;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    w_par_nxt   = r_par;
`endif
    if (r_state == FR_IDLE) begin
      if (w_fall && !r_dat_s2) begin
        w_state_nxt = FR_DATA;
        w_cnt_nxt   = 3'd0;
      end
    end else if (w_fall) begin
      case (r_state)
        FR_DATA: begin
          w_shift_nxt = {r_dat_s2, r_shift[7:1]};
          w_cnt_nxt   = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_nxt = FR_PARITY;
        end
        FR_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          w_par_nxt   = r_dat_s2;
`endif
          w_state_nxt = FR_STOP;
        end
        FR_STOP: begin
          w_state_nxt = FR_IDLE;
          if (r_dat_s2 && w_par_ok) w_valid_nxt = 1'b1;
          else                      w_err_nxt   = 1'b1;
        end
        default: w_state_nxt = FR_IDLE;
      endcase
    end else if (r_timer == c_TMAX) begin
      w_state_nxt = FR_IDLE;
      w_err_nxt   = 1'b1;
    end else begin
      w_timer_nxt = r_timer + 1'b1;
    end
  end

  assign rx_byte    = r_shift;
  assign byte_valid = r_valid;
  assign frame_err  = r_err;

endmodule

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// ============================================================================
// Module      : ps2_key_decoder
// Description : Decodes PS/2 set-2 scan codes (E0/F0 prefixes) into a held-key
//               mask, the last held make code and a key-event pulse.
//               Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking
//               in the frame receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 130000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [5:0] key,
  output logic [7:0] keycode,
  output logic       key_event,
  output logic       frame_err
);

  logic [7:0] w_rx_byte;
  logic       w_byte_valid;
  logic       w_ext;
  logic [5:0] w_mask;

  dec_state_t r_state, w_state_nxt;
  logic [5:0] r_key, w_key_nxt;
  logic [7:0] r_keycode, w_keycode_nxt;
  logic       r_event, w_event_nxt;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .pclk       (pclk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (w_rx_byte),
    .byte_valid (w_byte_valid),
    .frame_err  (frame_err)
  );

  assign w_ext  = (r_state == DEC_EXT) || (r_state == DEC_EXT_BRK);
  assign w_mask = key_mask(w_rx_byte, w_ext);

  // Decoder state and registered outputs
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state   <= DEC_BASE;
      r_key     <= 6'b000000;
      r_keycode <= 8'h00;
      r_event   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_key     <= w_key_nxt;
      r_keycode <= w_keycode_nxt;
      r_event   <= w_event_nxt;
    end
  end

  // Prefix tracking and make/break handling, one byte per byte_valid
  always_comb begin
    w_state_nxt   = r_state;
    w_key_nxt     = r_key;
    w_keycode_nxt = r_keycode;
    w_event_nxt   = 1'b0;
    if (w_byte_valid) begin
      if (is_discard(w_rx_byte)) begin
        w_state_nxt = DEC_BASE;
      end else begin
        case (r_state)
          DEC_BASE, DEC_EXT: begin
            if (w_rx_byte == CODE_F0) begin
              w_state_nxt = (r_state == DEC_EXT) ? DEC_EXT_BRK : DEC_BRK;
            end else if (w_rx_byte == CODE_E0 && r_state == DEC_BASE) begin
              w_state_nxt = DEC_EXT;
            end else begin
              // make code (typematic repeats pulse again)
              w_state_nxt   = DEC_BASE;
              w_key_nxt     = r_key | w_mask;
              w_keycode_nxt = w_rx_byte;
              w_event_nxt   = 1'b1;
            end
          end
          default: begin
            // break code; keycode clears only if it is the one being released
            w_state_nxt = DEC_BASE;
            w_key_nxt   = r_key & ~w_mask;
            if (w_rx_byte == r_keycode) w_keycode_nxt = 8'h00;
          end
        endcase
      end
    end
  end

  assign key       = r_key;
  assign keycode   = r_keycode;
  assign key_event = r_event;

endmodule

`default_nettype wire
